// File: rtl/dmem_ctrl.sv
// Handshaked MEM-stage data memory: byte/half/word little-endian access, wait states, clear sweep.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halves/words and the reserved size.
module dmem_ctrl #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_fault,
   output logic                  busy
);

   localparam int IDXW = $clog2(DEPTH);

   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [IDXW-1:0]       clr_idx;
   logic [3:0]            cnt;
   logic                  lat_write;
   logic [1:0]            lat_size;
   logic                  lat_unsigned;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [31:0]           lat_wdata;

   logic [31:0] mem [DEPTH];

   // The access being decoded: live request inputs in IDLE (zero-wait commit), latched copy otherwise.
   logic                  cur_write;
   logic [1:0]            cur_size;
   logic                  cur_unsigned;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [31:0]           cur_wdata;

   assign cur_write    = (state == IDLE) ? req_write    : lat_write;
   assign cur_size     = (state == IDLE) ? req_size     : lat_size;
   assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
   assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
   assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;

   logic [IDXW-1:0] cur_idx;
   logic [1:0]      lane;
   logic            range_fault;
   logic            align_fault;
   logic            fault;

   assign cur_idx     = cur_addr[IDXW+1:2];
   assign lane        = cur_addr[1:0];
   assign range_fault = |cur_addr[ADDR_WIDTH-1:IDXW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign align_fault = (cur_size == 2'b11) ||
                        ((cur_size == 2'b01) && lane[0]) ||
                        ((cur_size == 2'b10) && (lane != 2'b00));
`else
   assign align_fault = 1'b0;
`endif

   assign fault = range_fault | align_fault;

   // Lane merge for stores and extract/extend for loads; size 11 falls through as a word.
   logic [31:0] old_word;
   logic [31:0] merged;
   logic [31:0] load_val;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      old_word = mem[cur_idx];
      merged   = old_word;
      load_val = old_word;
      sel_b    = old_word[{lane, 3'b000} +: 8];
      sel_h    = old_word[{lane[1], 4'b0000} +: 16];
      case (cur_size)
         2'b00: begin
            merged[{lane, 3'b000} +: 8] = cur_wdata[7:0];
            load_val = cur_unsigned ? {24'b0, sel_b} : {{24{sel_b[7]}}, sel_b};
         end
         2'b01: begin
            merged[{lane[1], 4'b0000} +: 16] = cur_wdata[15:0];
            load_val = cur_unsigned ? {16'b0, sel_h} : {{16{sel_h[15]}}, sel_h};
         end
         default: begin
            merged   = cur_wdata;
            load_val = old_word;
         end
      endcase
   end

   logic [31:0] resp_val;
   logic        commit;

   assign resp_val = (fault || cur_write) ? 32'h0 : load_val;
   assign commit   = ((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));

   logic            mem_we;
   logic [IDXW-1:0] mem_waddr;
   logic [31:0]     mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = cur_idx;
      mem_wdata = merged;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_idx;
         mem_wdata = 32'h0;
      end else if (commit && cur_write && !fault) begin
         mem_we = 1'b1;
      end
   end

   // Storage has no reset; the sweep clears it after every reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   // Control FSM with all handshake and response outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= CLEAR;
         clr_idx      <= '0;
         cnt          <= '0;
         lat_write    <= 1'b0;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'h0;
         resp_fault   <= 1'b0;
         busy         <= 1'b1;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == IDXW'(DEPTH - 1)) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            IDLE: begin
               if (req_valid) begin
                  lat_write    <= req_write;
                  lat_size     <= req_size;
                  lat_unsigned <= req_unsigned;
                  lat_addr     <= req_addr;
                  lat_wdata    <= req_wdata;
                  cnt          <= 4'(WAIT_STATES);
                  req_ready    <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= resp_val;
                     resp_fault <= fault;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == 4'd1) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= resp_val;
                  resp_fault <= fault;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: a DEPTH=1024/WAIT_STATES=1 instance and a
// small DEPTH=16/WAIT_STATES=3 instance for wait-state latency and range checks.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic        resp_valid, resp_fault, busy;

   logic        rst3, req3_valid, req3_ready, req3_write, req3_unsigned;
   logic [1:0]  req3_size;
   logic [31:0] req3_addr, req3_wdata, resp3_rdata;
   logic        resp3_valid, resp3_fault, busy3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH(1024), .ADDR_WIDTH(32), .WAIT_STATES(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault), .busy(busy)
   );

   dmem_ctrl #(.DEPTH(16), .ADDR_WIDTH(32), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst(rst3), .req_valid(req3_valid), .req_ready(req3_ready),
      .req_write(req3_write), .req_size(req3_size), .req_unsigned(req3_unsigned),
      .req_addr(req3_addr), .req_wdata(req3_wdata), .resp_valid(resp3_valid),
      .resp_rdata(resp3_rdata), .resp_fault(resp3_fault), .busy(busy3)
   );

   // Drives one request on the main instance; returns at the negedge of the response cycle.
   task automatic access(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 5000) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
      rd = resp_rdata; flt = resp_fault;
   endtask

   task automatic test_reset();
      int n, lat;
      rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      total += 5;
      if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b exp=0", req_ready); end
      if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", resp_valid); end
      if (resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata got=%h exp=0", resp_rdata); end
      if (resp_fault !== 1'b0) begin bad++; $display("[TB] FAIL rst_fault got=%b exp=0", resp_fault); end
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=1", busy); end
      rst = 1'b0;
      n = 0;
      while (!req_ready && n < 3000) begin
         @(negedge clk); n++;
         if (n == 1023) begin
            total++;
            if (busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_sweep got=%b exp=1", busy); end
         end
      end
      total += 2;
      if (n !== 1024) begin bad++; $display("[TB] FAIL clear_latency got=%0d exp=1024", n); end
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_done got=%b exp=0", busy); end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
      total += 3;
      if (lat !== 2) begin bad++; $display("[TB] FAIL first_lat got=%0d exp=2", lat); end
      if (resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL first_rdata got=%h exp=0", resp_rdata); end
      if (resp_fault !== 1'b0) begin bad++; $display("[TB] FAIL first_fault got=%b exp=0", resp_fault); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic f; int lat;
      access(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, f, lat);
      total += 2;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL top_word got=%h exp=0", rd); end
      if (lat !== 2) begin bad++; $display("[TB] FAIL top_lat got=%0d exp=2", lat); end
      access(1'b1, 2'b10, 1'b0, 32'h80, 32'h8C0A0020, rd, f, lat);
      total += 2;
      if (rd !== 32'h0 || f !== 1'b0) begin bad++; $display("[TB] FAIL store_resp got=%h/%b exp=0/0", rd, f); end
      if (lat !== 2) begin bad++; $display("[TB] FAIL store_lat got=%0d exp=2", lat); end
      access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, f, lat);
      total++;
      if (rd !== 32'h8C0A0020) begin bad++; $display("[TB] FAIL word_rt got=%h exp=8c0a0020", rd); end
   endtask

   task automatic test_byte_merge();
      logic [31:0] rd; logic f; int lat;
      access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, rd, f, lat);
      access(1'b1, 2'b00, 1'b0, 32'h102, 32'hAAAAAA55, rd, f, lat);
      access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, f, lat);
      total++;
      if (rd !== 32'hDE55BEEF) begin bad++; $display("[TB] FAIL byte_merge got=%h exp=de55beef", rd); end
   endtask

   task automatic test_extension();
      logic [31:0] addrs [8] = '{32'h101, 32'h102, 32'h100, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
      logic [1:0]  sizes [8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
      logic        unss  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] exps  [8] = '{32'hFFFFFFBE, 32'h0000DE55, 32'hFFFFBEEF, 32'h000000DE,
                                 32'h00000055, 32'hFFFFDE55, 32'h000000EF, 32'hDE55BEEF};
      logic [31:0] rd; logic f; int lat;
      for (int i = 0; i < 8; i++) begin
         access(1'b0, sizes[i], unss[i], addrs[i], 32'h0, rd, f, lat);
         total++;
         if (rd !== exps[i] || f !== 1'b0)
            begin bad++; $display("[TB] FAIL ext_%0d got=%h/%b exp=%h/0", i, rd, f, exps[i]); end
      end
   endtask

   task automatic test_faults();
      logic [31:0] addrs [7] = '{32'h1000, 32'hFFC, 32'h0, 32'h102, 32'h1000, 32'h101, 32'h100};
      logic        wrs   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [1:0]  sizes [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
`ifdef DMEM_MISALIGN_TRAP_EN
      logic [31:0] exps  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      logic        fexp  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
      logic [31:0] exps  [7] = '{32'h0, 32'h0, 32'h0, 32'hDE55BEEF, 32'h0, 32'hFFFFBEEF, 32'hDE55BEEF};
      logic        fexp  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
      logic [31:0] rd; logic f; int lat;
      for (int i = 0; i < 7; i++) begin
         access(wrs[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF, rd, f, lat);
         total++;
         if (rd !== exps[i] || f !== fexp[i])
            begin bad++; $display("[TB] FAIL fault_%0d got=%h/%b exp=%h/%b", i, rd, f, exps[i], fexp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic f; int lat;
      access(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, rd, f, lat);
      access(1'b1, 2'b01, 1'b0, 32'h302, 32'hFFFF1234, rd, f, lat);
      access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, rd, f, lat);
      total += 3;
      if (rd !== 32'h1234F00D) begin bad++; $display("[TB] FAIL b2b_data got=%h exp=1234f00d", rd); end
      if (lat !== 2) begin bad++; $display("[TB] FAIL b2b_lat got=%0d exp=2", lat); end
      if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ready_resp got=%b exp=0", req_ready); end
      @(negedge clk);
      total += 3;
      if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_pulse got=%b exp=0", resp_valid); end
      if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_next got=%b exp=1", req_ready); end
      if (resp_rdata !== 32'h1234F00D) begin bad++; $display("[TB] FAIL b2b_hold got=%h exp=1234f00d", resp_rdata); end
   endtask

   task automatic test_wait_states();
      logic [31:0] addrs [3] = '{32'h3C, 32'h3C, 32'h40};
      logic        wrs   [3] = '{1'b1, 1'b0, 1'b0};
      logic [31:0] exps  [3] = '{32'h0, 32'hA5A5A5A5, 32'h0};
      logic        fexp  [3] = '{1'b0, 1'b0, 1'b1};
      int n, lat;
      rst3 = 1'b0;
      n = 0;
      while (!req3_ready && n < 200) begin @(negedge clk); n++; end
      total++;
      if (n !== 16) begin bad++; $display("[TB] FAIL ws3_clear got=%0d exp=16", n); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req3_valid = 1'b1; req3_write = wrs[i]; req3_size = 2'b10; req3_unsigned = 1'b0;
         req3_addr = addrs[i]; req3_wdata = 32'hA5A5A5A5;
         n = 0;
         while (!req3_ready && n < 200) begin @(negedge clk); n++; end
         @(negedge clk);
         req3_valid = 1'b0;
         lat = 1;
         while (!resp3_valid && lat < 40) begin @(negedge clk); lat++; end
         total += 2;
         if (lat !== 4) begin bad++; $display("[TB] FAIL ws3_lat_%0d got=%0d exp=4", i, lat); end
         if (resp3_rdata !== exps[i] || resp3_fault !== fexp[i])
            begin bad++; $display("[TB] FAIL ws3_resp_%0d got=%h/%b exp=%h/%b", i, resp3_rdata, resp3_fault, exps[i], fexp[i]); end
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd; logic f; int n, lat, seen;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h200; req_wdata = 32'h12345678;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      total += 3;
      if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_valid got=%b exp=0", resp_valid); end
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rw_busy got=%b exp=1", busy); end
      if (resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rw_rdata got=%h exp=0", resp_rdata); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0; n = 0;
      while (!req_ready && n < 3000) begin @(negedge clk); n++; if (resp_valid) seen++; end
      total += 2;
      if (seen !== 0) begin bad++; $display("[TB] FAIL rw_noresp got=%0d exp=0", seen); end
      if (n !== 1024) begin bad++; $display("[TB] FAIL rw_clear got=%0d exp=1024", n); end
      access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, f, lat);
      total++;
      if (rd !== 32'h0 || f !== 1'b0) begin bad++; $display("[TB] FAIL rw_dropped got=%h/%b exp=0/0", rd, f); end
      access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, f, lat);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rw_swept got=%h exp=0", rd); end
   endtask

   initial begin
      rst3 = 1'b1; req3_valid = 1'b0; req3_write = 1'b0; req3_size = 2'b10;
      req3_unsigned = 1'b0; req3_addr = 32'h0; req3_wdata = 32'h0;
      test_reset();
      test_word();
      test_byte_merge();
      test_extension();
      test_faults();
      test_back_to_back();
      test_wait_states();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
